// File: rtl/serial_pkg.sv
// rtl/serial_pkg.sv - shared constants and state encoding for the serial frame parser
package serial_pkg;

  localparam logic [7:0] SOF_DEFAULT = 8'hAA;

  typedef enum logic [2:0] {
    IDLE,
    S_CMD,
    S_LEN,
    S_PAY,
    S_CSUM
  } state_t;

  localparam logic [1:0] ERR_CSUM = 2'd1;
  localparam logic [1:0] ERR_LEN  = 2'd2;
  localparam logic [1:0] ERR_TMO  = 2'd3;

endpackage

// File: rtl/serial_idle_timer.sv
// rtl/serial_idle_timer.sv - clearable/loadable idle counter with a terminal-count flag
module serial_idle_timer #(
  parameter int TIMEOUT = 500000,
  parameter int CW      = $clog2(TIMEOUT + 1)
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          clr,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  output logic          tc
);

  logic [CW-1:0] cnt;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST)      cnt <= '0;
    else if (clr)  cnt <= '0;
    else if (load) cnt <= load_val;
    else           cnt <= cnt + CW'(1);
  end

  assign tc = (cnt == CW'(TIMEOUT - 1));

endmodule

// File: rtl/serial_frame_parser.sv
// rtl/serial_frame_parser.sv - SOF/CMD/LEN/payload/CSUM frame decoder on the FIFO read side
module serial_frame_parser
  import serial_pkg::*;
#(
  parameter int          MAXLEN  = 16,
  parameter int          TIMEOUT = 500000,
  parameter logic [7:0]  SOF     = SOF_DEFAULT,
  parameter int          AW      = (MAXLEN > 1) ? $clog2(MAXLEN) : 1
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          DATA_RDY,
  input  logic [7:0]    DATA,
  output logic          RD_EN,
  output logic [7:0]    CMD,
  output logic [7:0]    LEN,
  output logic [7:0]    PL_DATA,
  output logic [AW-1:0] PL_ADDR,
  output logic          PL_WE,
  output logic          FRAME_OK,
  output logic          FRAME_ERR,
  output logic [1:0]    ERR_CODE,
  output logic          BUSY
);

  localparam logic [7:0] MAXLEN_B = 8'(MAXLEN);
  localparam int         CW       = $clog2(TIMEOUT + 1);

  state_t        state, state_nx;
  logic          accept, tmo_tc, tmo, last_pay, len_bad;
  logic [7:0]    csum;
  logic [AW-1:0] idx;
  logic          pl_we_d, ok_d, err_d;
  logic [1:0]    code_d;

  // RD_EN doubles as the accept strobe: DATA is captured on the edge that ends it
  assign accept   = RD_EN;
  assign len_bad  = (DATA > MAXLEN_B);
  assign last_pay = (8'(idx) == LEN - 8'd1);
  assign tmo      = tmo_tc & ~accept & (state != IDLE);
  assign BUSY     = (state != IDLE);

  serial_idle_timer #(.TIMEOUT(TIMEOUT), .CW(CW)) u_idle_timer (
    .CLK      (CLK),
    .RST      (RST),
    .clr      (accept | (state == IDLE)),
    .load     (1'b0),
    .load_val ('0),
    .tc       (tmo_tc)
  );

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (accept) begin
      case (state)
        IDLE:    if (DATA == SOF) state_nx = S_CMD;
        S_CMD:   state_nx = S_LEN;
        S_LEN:   begin
          if (len_bad)            state_nx = IDLE;
          else if (DATA == 8'd0)  state_nx = S_CSUM;
          else                    state_nx = S_PAY;
        end
        S_PAY:   if (last_pay) state_nx = S_CSUM;
        S_CSUM:  state_nx = IDLE;
        default: state_nx = IDLE;
      endcase
    end else if (tmo) begin
      state_nx = IDLE;
    end
  end

  always_comb begin
    pl_we_d = 1'b0;
    ok_d    = 1'b0;
    err_d   = 1'b0;
    code_d  = ERR_CODE;
    if (accept) begin
      case (state)
        S_LEN:  if (len_bad) begin err_d = 1'b1; code_d = ERR_LEN; end
        S_PAY:  pl_we_d = 1'b1;
        S_CSUM: begin
          if (DATA == csum) ok_d = 1'b1;
          else begin err_d = 1'b1; code_d = ERR_CSUM; end
        end
        default: ;
      endcase
    end else if (tmo) begin
      err_d  = 1'b1;
      code_d = ERR_TMO;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      RD_EN     <= 1'b0;
      CMD       <= '0;
      LEN       <= '0;
      PL_DATA   <= '0;
      PL_ADDR   <= '0;
      PL_WE     <= 1'b0;
      FRAME_OK  <= 1'b0;
      FRAME_ERR <= 1'b0;
      ERR_CODE  <= '0;
      csum      <= '0;
      idx       <= '0;
    end else begin
      RD_EN     <= DATA_RDY & ~RD_EN;
      PL_WE     <= pl_we_d;
      FRAME_OK  <= ok_d;
      FRAME_ERR <= err_d;
      ERR_CODE  <= code_d;
      if (accept) begin
        case (state)
          IDLE:  csum <= '0;
          S_CMD: begin CMD <= DATA; csum <= DATA; end
          S_LEN: begin LEN <= DATA; csum <= csum ^ DATA; idx <= '0; end
          S_PAY: begin
            PL_DATA <= DATA;
            PL_ADDR <= idx;
            idx     <= idx + AW'(1);
            csum    <= csum ^ DATA;
          end
          default: ;
        endcase
      end
    end
  end

endmodule
